// File: rtl/core_isa_pkg.sv
// Shared ISA definitions for the 4-bit-opcode core: opcode encoding,
// instruction field positions, fetch FSM states and the immediate extender.
package core_isa_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_ORR = 4'b0011,
      OP_LSL = 4'b0100,
      OP_CMP = 4'b0101,
      OP_SET = 4'b0110,
      OP_LDR = 4'b0111,
      OP_STR = 4'b1000,
      OP_B   = 4'b1001,
      OP_BEQ = 4'b1010,
      OP_BGE = 4'b1011,
      OP_NOP = 4'b1111
   } opcodeT;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } fetchStateT;

   localparam int WORD_W     = 32;
   localparam int OP_MSB     = 31;
   localparam int OP_LSB     = 28;
   localparam int IMM_BIT    = 27;
   localparam int RD_MSB     = 26;
   localparam int RD_LSB     = 23;
   localparam int RS1_MSB    = 22;
   localparam int RS1_LSB    = 19;
   localparam int RS2_MSB    = 18;
   localparam int RS2_LSB    = 15;
   localparam int IMMVAL_MSB = 14;

   // Sign-extend the 15-bit immediate field to a full data word.
   function automatic logic signed [WORD_W-1:0] signExtImm(input logic [WORD_W-1:0] word);
      return {{(WORD_W-IMMVAL_MSB-1){word[IMMVAL_MSB]}}, word[IMMVAL_MSB:0]};
   endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// Output register plus one skid entry between the instruction memory
// response and decode. The skid always drains ahead of newer words so
// program order is preserved; flush drops both entries.
module instr_skid_buf #(
   parameter int DATA_W = 42
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              inVld,
   output logic              inRdy,
   input  logic [DATA_W-1:0] inData,
   output logic              outVld,
   input  logic              outRdy,
   output logic [DATA_W-1:0] outData,
   output logic              skidFull
);

   logic              skidVld;
   logic [DATA_W-1:0] skidData;
   logic              consume;
   logic              loadSkid;

   assign consume  = outVld & outRdy;
   assign inRdy    = !skidVld || consume;
   assign skidFull = skidVld;

   // A word lands in the skid when the skid is being drained this cycle,
   // or when the output register is occupied and held.
   assign loadSkid = !flush && inVld && (skidVld ? consume : (outVld && !consume));

   // Occupancy flags and the output register (visible to decode, so reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outVld  <= 1'b0;
         skidVld <= 1'b0;
         outData <= '0;
      end else if (flush) begin
         outVld  <= 1'b0;
         skidVld <= 1'b0;
      end else if (skidVld) begin
         if (consume) begin
            outData <= skidData;
            skidVld <= inVld;
         end
      end else if (inVld) begin
         if (!outVld || consume) begin
            outData <= inData;
            outVld  <= 1'b1;
         end else begin
            skidVld <= 1'b1;
         end
      end else if (consume) begin
         outVld <= 1'b0;
      end
   end

   // Skid payload; meaningful only while skidVld is set.
   always_ff @(posedge clk) begin
      if (loadSkid) skidData <= inData;
   end

endmodule

// File: rtl/fetch_issue_unit.sv
// Fetch and issue stage: owns the PC, drives the synchronous instruction
// memory, tags each read with the current epoch and issues sliced fields
// to decode through a two-entry skid buffer. Redirects flush the buffer,
// flip the epoch and restart fetch from the target.
module fetch_issue_unit
   import core_isa_pkg::*;
#(
   parameter int                ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [3:0]        id_operation,
   output logic              id_imm,
   output logic [3:0]        id_rd,
   output logic [3:0]        id_rs1,
   output logic [3:0]        id_rs2,
   output logic [31:0]       id_immval,
   output logic [ADDR_W-1:0] id_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int BUF_W = ADDR_W + WORD_W;

   fetchStateT         state;
   logic [ADDR_W-1:0]  pc;
   logic               epoch;
   logic               rdVld_p1;
   logic               rdEpoch_p1;
   logic [ADDR_W-1:0]  rdPc_p1;
   logic               fetchEn;
   logic [1:0]         occupancy;
   logic               bufInVld;
   logic               bufInRdy;
   logic               bufOutVld;
   logic [BUF_W-1:0]   bufOutData;
   logic               skidFull;
   logic [WORD_W-1:0]  issWord;
   logic signed [WORD_W-1:0] issImm;

   // Words already owned by this stage after this cycle's hand-off:
   // output register, skid entry and the read returning now.
   assign occupancy = {1'b0, bufOutVld} + {1'b0, skidFull} + {1'b0, rdVld_p1}
                    - {1'b0, bufOutVld & id_ready};

   // Fetch decision; a redirect suppresses fetch in its own cycle.
   always_comb begin
      fetchEn = 1'b0;
      if (!redirect_valid) begin
         case (state)
            BOOT, REDIRECT: fetchEn = 1'b1;
            RUN:            fetchEn = (occupancy < 2'd2) && bufInRdy;
            default:        fetchEn = 1'b0;
         endcase
      end
   end

   assign imem_en   = fetchEn & rst_n;
   assign imem_addr = pc;

   // Fetch FSM, PC and in-flight read tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         pc         <= RESET_PC;
         epoch      <= 1'b0;
         rdVld_p1   <= 1'b0;
         rdEpoch_p1 <= 1'b0;
      end else begin
         rdVld_p1   <= fetchEn;
         rdEpoch_p1 <= epoch;
         if (redirect_valid) begin
            state <= REDIRECT;
            pc    <= redirect_pc;
            epoch <= ~epoch;
         end else begin
            state <= RUN;
            if (fetchEn) pc <= pc + 1'b1;
         end
      end
   end

   // Address of the read in flight travels with it to the response.
   always_ff @(posedge clk) begin
      rdPc_p1 <= pc;
   end

   // ---- response stage: drop wrong-path words, buffer the rest ----
   assign bufInVld = rdVld_p1 && (rdEpoch_p1 == epoch);

   instr_skid_buf #(
      .DATA_W (BUF_W)
   ) uSkid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .inVld    (bufInVld),
      .inRdy    (bufInRdy),
      .inData   ({rdPc_p1, imem_rdata}),
      .outVld   (bufOutVld),
      .outRdy   (id_ready),
      .outData  (bufOutData),
      .skidFull (skidFull)
   );

   // ---- issue stage: slice fields out of the output register ----
   assign issWord      = bufOutData[WORD_W-1:0];
   assign issImm       = signExtImm(issWord);
   assign id_valid     = bufOutVld;
   assign id_pc        = bufOutData[BUF_W-1:WORD_W];
   assign id_operation = issWord[OP_MSB:OP_LSB];
   assign id_imm       = issWord[IMM_BIT];
   assign id_rd        = issWord[RD_MSB:RD_LSB];
   assign id_rs1       = issWord[RS1_MSB:RS1_LSB];
   assign id_rs2       = issWord[RS2_MSB:RS2_LSB];
   assign id_immval    = issImm;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Bench for fetch_issue_unit: directed timing scenarios plus a randomized
// stream scored against a program-order model of the issued PCs.
module tb_fetch_issue_unit;

   localparam int                ADDR_W   = 10;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   logic              clk;
   logic              rst_n;
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              id_valid;
   logic              id_ready;
   logic [3:0]        id_operation;
   logic              id_imm;
   logic [3:0]        id_rd;
   logic [3:0]        id_rs1;
   logic [3:0]        id_rs2;
   logic [31:0]       id_immval;
   logic [ADDR_W-1:0] id_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   fetch_issue_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_operation   (id_operation),
      .id_imm         (id_imm),
      .id_rd          (id_rd),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_immval      (id_immval),
      .id_pc          (id_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous instruction memory
   logic [31:0] memArr [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= memArr[imem_addr];
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Observations of the current cycle
   logic              oValid, oEn, oImm;
   logic [ADDR_W-1:0] oPc, oAddr;
   logic [3:0]        oOp, oRd, oRs1, oRs2;
   logic [31:0]       oImmv;

   // Model: next PC decode must receive, plus expected fields of a word
   logic [ADDR_W-1:0] expNext;
   logic [3:0]        eOp, eRd, eRs1, eRs2;
   logic              eImm;
   logic [31:0]       eImmv;

   task automatic sample();
      oValid = id_valid; oPc = id_pc; oOp = id_operation; oImm = id_imm;
      oRd = id_rd; oRs1 = id_rs1; oRs2 = id_rs2; oImmv = id_immval;
      oEn = imem_en; oAddr = imem_addr;
   endtask

   task automatic expectFor(input logic [ADDR_W-1:0] a);
      logic [31:0] w;
      w     = memArr[a];
      eOp   = 4'((w >> 28) & 32'hF);
      eImm  = ((w >> 27) & 32'h1) != 0;
      eRd   = 4'((w >> 23) & 32'hF);
      eRs1  = 4'((w >> 19) & 32'hF);
      eRs2  = 4'((w >> 15) & 32'hF);
      eImmv = w & 32'h7FFF;
      if ((w & 32'h4000) != 0) eImmv = eImmv | 32'hFFFF_8000;
   endtask

   task automatic tick(input logic rdy, input logic rv, input logic [ADDR_W-1:0] rp);
      @(posedge clk); #1;
      id_ready = rdy; redirect_valid = rv; redirect_pc = rp;
      #2;
      sample();
      cyc++;
   endtask

   task automatic holdReset();
      @(posedge clk); #1;
      rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
   endtask

   // Release reset just after an edge; the cycle that follows is cycle 0.
   task automatic startRun(input logic rdy);
      @(posedge clk); #1;
      rst_n = 1'b1; id_ready = rdy; redirect_valid = 1'b0; redirect_pc = '0;
      #2;
      sample();
      cyc = 0;
      expNext = RESET_PC;
   endtask

   task automatic fillStream();
      for (int k = 0; k < (1<<ADDR_W); k++) memArr[k] = (k & 32'hF) << 28;
   endtask

   task automatic test_reset();
      holdReset(); #3; sample();
      total++;
      if (oValid !== 1'b0 || oEn !== 1'b0 || oAddr !== RESET_PC)
         $display("FAIL reset_ctrl: valid=%b en=%b addr=%h want 0 0 %h", oValid, oEn, oAddr, RESET_PC);
      total++;
      if ({oPc, oOp, oImm, oRd, oRs1, oRs2, oImmv} !== '0)
         $display("FAIL reset_fields: pc=%h op=%h immv=%h want all zero", oPc, oOp, oImmv);
      startRun(1'b1);
      total++;
      if (oEn !== 1'b1 || oAddr !== RESET_PC || oValid !== 1'b0)
         $display("FAIL boot_fetch: en=%b addr=%h valid=%b want 1 %h 0", oEn, oAddr, oValid, RESET_PC);
      if (oEn !== 1'b1 || oAddr !== RESET_PC || oValid !== 1'b0) bad++;
   endtask

   task automatic test_stream();
      logic [ADDR_W-1:0] ePc;
      for (int i = 0; i < 12; i++) begin
         tick(1'b1, 1'b0, '0);
         total++;
         if (cyc < 2) begin
            if (oValid !== 1'b0) begin
               bad++; $display("FAIL stream_latency c%0d: valid=%b want 0", cyc, oValid);
            end
         end else begin
            ePc = ADDR_W'(cyc - 2);
            if (oValid !== 1'b1 || oPc !== ePc || oOp !== ePc[3:0]) begin
               bad++;
               $display("FAIL stream c%0d: valid=%b pc=%h op=%h want 1 %h %h", cyc, oValid, oPc, oOp, ePc, ePc[3:0]);
            end
            expNext = expNext + 1'b1;
         end
      end
   endtask

   task automatic test_stall();
      logic [ADDR_W-1:0] hPc;
      logic [3:0]        hOp;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, '0);
         if (i == 0) begin hPc = expNext; hOp = expNext[3:0]; end
         total++;
         if (oValid !== 1'b1 || oPc !== hPc || oOp !== hOp || oEn !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold s%0d: valid=%b pc=%h op=%h en=%b want 1 %h %h 0", i, oValid, oPc, oOp, oEn, hPc, hOp);
         end
      end
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b0, '0);
         total++;
         if (oValid !== 1'b1 || oPc !== expNext) begin
            bad++; $display("FAIL stall_release r%0d: valid=%b pc=%h want 1 %h", i, oValid, oPc, expNext);
         end
         expNext = expNext + 1'b1;
      end
   endtask

   task automatic test_redirect();
      tick(1'b1, 1'b1, 10'h040);
      total++;
      if (oEn !== 1'b0) begin bad++; $display("FAIL redirect_nofetch: en=%b want 0", oEn); end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b0 || oEn !== 1'b1 || oAddr !== 10'h040) begin
         bad++; $display("FAIL redirect_n1: valid=%b en=%b addr=%h want 0 1 040", oValid, oEn, oAddr);
      end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b0) begin bad++; $display("FAIL redirect_n2: valid=%b want 0", oValid); end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b1 || oPc !== 10'h040 || oOp !== 4'h0) begin
         bad++; $display("FAIL redirect_n3: valid=%b pc=%h op=%h want 1 040 0", oValid, oPc, oOp);
      end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b1 || oPc !== 10'h041 || oOp !== 4'h1) begin
         bad++; $display("FAIL redirect_n4: valid=%b pc=%h op=%h want 1 041 1", oValid, oPc, oOp);
      end
   endtask

   task automatic test_fields();
      memArr[10'h060] = 32'h5800_0007;
      memArr[10'h061] = 32'h0000_7FFF;
      tick(1'b1, 1'b1, 10'h060);
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b1 || oPc !== 10'h060 || oOp !== 4'b0101 || oImm !== 1'b1 || oRd !== 4'h0
          || oRs1 !== 4'h0 || oRs2 !== 4'h0 || oImmv !== 32'h0000_0007) begin
         bad++;
         $display("FAIL fields_cmp: pc=%h op=%h imm=%b rd=%h immv=%h want 060 5 1 0 00000007", oPc, oOp, oImm, oRd, oImmv);
      end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b1 || oPc !== 10'h061 || oImmv !== 32'hFFFF_FFFF || oOp !== 4'h0) begin
         bad++; $display("FAIL fields_sext: pc=%h immv=%h want 061 ffffffff", oPc, oImmv);
      end
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] ePc;
      tick(1'b1, 1'b1, 10'h3FE);
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      ePc = 10'h3FE;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, '0);
         total++;
         if (oValid !== 1'b1 || oPc !== ePc || oOp !== ePc[3:0]) begin
            bad++; $display("FAIL wrap w%0d: valid=%b pc=%h op=%h want 1 %h %h", i, oValid, oPc, oOp, ePc, ePc[3:0]);
         end
         ePc = ePc + 1'b1;
      end
   endtask

   task automatic test_back_to_back();
      tick(1'b1, 1'b1, 10'h100);
      tick(1'b1, 1'b1, 10'h200);
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b0 || oEn !== 1'b1 || oAddr !== 10'h200) begin
         bad++; $display("FAIL b2b_fetch: valid=%b en=%b addr=%h want 0 1 200", oValid, oEn, oAddr);
      end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b0) begin bad++; $display("FAIL b2b_gap: valid=%b want 0", oValid); end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b1 || oPc !== 10'h200) begin
         bad++; $display("FAIL b2b_target: valid=%b pc=%h want 1 200", oValid, oPc);
      end
   endtask

   task automatic test_async_reset();
      repeat (3) tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b1) begin bad++; $display("FAIL areset_pre: valid=%b want 1", oValid); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1; sample();
      total++;
      if (oValid !== 1'b0 || oEn !== 1'b0 || oAddr !== RESET_PC) begin
         bad++; $display("FAIL areset_now: valid=%b en=%b addr=%h want 0 0 %h", oValid, oEn, oAddr, RESET_PC);
      end
      repeat (2) @(posedge clk);
      startRun(1'b1);
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b0) begin bad++; $display("FAIL areset_c1: valid=%b want 0", oValid); end
      tick(1'b1, 1'b0, '0);
      total++;
      if (oValid !== 1'b1 || oPc !== RESET_PC) begin
         bad++; $display("FAIL areset_c2: valid=%b pc=%h want 1 %h", oValid, oPc, RESET_PC);
      end
   endtask

   task automatic test_random();
      logic              rdy, rv, prevHold;
      logic [ADDR_W-1:0] rp, hPc;
      logic [3:0]        hOp, hRd;
      logic [31:0]       hImmv;
      int                xfers;
      for (int k = 0; k < (1<<ADDR_W); k++) memArr[k] = $urandom;
      holdReset();
      startRun(1'b1);
      prevHold = 1'b0; xfers = 0;
      hPc = '0; hOp = '0; hRd = '0; hImmv = '0;
      for (int i = 0; i < 800; i++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 39) == 0);
         rp  = ADDR_W'($urandom);
         tick(rdy, rv, rp);
         if (prevHold) begin
            total++;
            if (oValid !== 1'b1 || oPc !== hPc || oOp !== hOp || oRd !== hRd || oImmv !== hImmv) begin
               bad++; $display("FAIL rand_hold c%0d: valid=%b pc=%h want 1 %h", cyc, oValid, oPc, hPc);
            end
         end
         if (oValid && rdy && !rv) begin
            expectFor(expNext);
            total++;
            if (oPc !== expNext || oOp !== eOp || oImm !== eImm || oRd !== eRd || oRs1 !== eRs1
                || oRs2 !== eRs2 || oImmv !== eImmv) begin
               bad++;
               $display("FAIL rand_issue c%0d: pc=%h op=%h immv=%h want %h %h %h", cyc, oPc, oOp, oImmv, expNext, eOp, eImmv);
            end
            expNext = expNext + 1'b1;
            xfers++;
         end
         if (rv) expNext = rp;
         prevHold = oValid && !rdy && !rv;
         hPc = oPc; hOp = oOp; hRd = oRd; hImmv = oImmv;
      end
      total++;
      if (xfers < 200) begin bad++; $display("FAIL rand_progress: transfers=%0d want >=200", xfers); end
   endtask

   initial begin
      rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      fillStream();
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_fields();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
